// File: rtl/sonar_median_filter.sv
`default_nettype none
// ============================================================================
// Module      : sonar_median_filter
// Description : Six-channel sonar distance filter with a valid/ready input and
//               a held-until-accepted output. Optional 3-tap median filter is
//               enabled by defining SONAR_MEDIAN_FILTER_EN. Per-channel flags
//               mark obstacles closer than THRESH.
// Revision    : 1.0 - initial release
// ============================================================================
module sonar_median_filter #(
    parameter logic [11:0] THRESH = 12'd300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_ctrl,
    input  logic [23:0] in_data,
    input  logic        in_wr,
    output logic        in_rdy,
    output logic [3:0]  out_ctrl,
    output logic [23:0] out_data,
    output logic        out_wr,
    input  logic        out_wr_rdy,
    output logic [5:0]  obstacle
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam int c_num_ch = 6;

    state_t      state_q, state_d;
    logic [2:0]  ch_q, ch_d;
    logic [11:0] s_q, s_d;
    logic [3:0]  out_ctrl_q, out_ctrl_d;
    logic [23:0] out_data_q, out_data_d;
    logic        out_wr_q, out_wr_d;
    logic [5:0]  obstacle_q, obstacle_d;
    logic [11:0] w_result;
    logic        w_beat_ok;
    logic        w_unused;

    // Upper sample bits carry no information for this block.
    assign w_unused  = ^in_data[23:12];
    assign w_beat_ok = !in_ctrl[3] && (in_ctrl[2:0] <= 3'd5);

`ifdef SONAR_MEDIAN_FILTER_EN
    logic [11:0] h0_q  [0:c_num_ch-1];
    logic [11:0] h0_d  [0:c_num_ch-1];
    logic [11:0] h1_q  [0:c_num_ch-1];
    logic [11:0] h1_d  [0:c_num_ch-1];
    logic [1:0]  cnt_q [0:c_num_ch-1];
    logic [1:0]  cnt_d [0:c_num_ch-1];
    logic [11:0] w_sel_h0;
    logic [11:0] w_sel_h1;
    logic [1:0]  w_sel_cnt;

    function automatic logic [11:0] median3(input logic [11:0] a,
                                            input logic [11:0] b,
                                            input logic [11:0] c);
        logic [11:0] lo;
        logic [11:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo)
            return lo;
        else if (c > hi)
            return hi;
        else
            return c;
    endfunction

    always_comb begin
        w_sel_h0  = '0;
        w_sel_h1  = '0;
        w_sel_cnt = '0;
        for (int i = 0; i < c_num_ch; i++) begin
            if (ch_q == 3'(i)) begin
                w_sel_h0  = h0_q[i];
                w_sel_h1  = h1_q[i];
                w_sel_cnt = cnt_q[i];
            end
        end
    end

    // A zero sample (no echo) falls through as s, which is already 0.
    always_comb begin
        w_result = s_q;
        if ((s_q != 12'd0) && (w_sel_cnt == 2'd2))
            w_result = median3(s_q, w_sel_h0, w_sel_h1);
    end

    always_comb begin
        for (int i = 0; i < c_num_ch; i++) begin
            h0_d[i]  = h0_q[i];
            h1_d[i]  = h1_q[i];
            cnt_d[i] = cnt_q[i];
        end
        if ((state_q == ST_CALC) && (s_q != 12'd0)) begin
            for (int i = 0; i < c_num_ch; i++) begin
                if (ch_q == 3'(i)) begin
                    h1_d[i]  = h0_q[i];
                    h0_d[i]  = s_q;
                    cnt_d[i] = (cnt_q[i] == 2'd2) ? 2'd2 : cnt_q[i] + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_num_ch; i++) begin
                h0_q[i]  <= '0;
                h1_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_num_ch; i++) begin
                h0_q[i]  <= h0_d[i];
                h1_q[i]  <= h1_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    assign w_result = s_q;
`endif

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        s_d        = s_q;
        out_ctrl_d = out_ctrl_q;
        out_data_d = out_data_q;
        out_wr_d   = out_wr_q;
        obstacle_d = obstacle_q;
        case (state_q)
            ST_IDLE: begin
                if (in_wr && w_beat_ok) begin
                    ch_d    = in_ctrl[2:0];
                    s_d     = in_data[11:0];
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                out_ctrl_d = {1'b0, ch_q};
                out_data_d = {12'b0, w_result};
                for (int i = 0; i < c_num_ch; i++) begin
                    if (ch_q == 3'(i))
                        obstacle_d[i] = (s_q != 12'd0) && (w_result < THRESH);
                end
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // First SEND cycle raises out_wr; the result is offered from then on.
                if (!out_wr_q) begin
                    out_wr_d = 1'b1;
                end else if (out_wr_rdy) begin
                    out_wr_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                out_wr_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            s_q        <= '0;
            out_ctrl_q <= '0;
            out_data_q <= '0;
            out_wr_q   <= 1'b0;
            obstacle_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            s_q        <= s_d;
            out_ctrl_q <= out_ctrl_d;
            out_data_q <= out_data_d;
            out_wr_q   <= out_wr_d;
            obstacle_q <= obstacle_d;
        end
    end

    assign in_rdy   = (state_q == ST_IDLE);
    assign out_wr   = out_wr_q;
    assign out_ctrl = out_ctrl_q;
    assign out_data = out_data_q;
    assign obstacle = obstacle_q;

endmodule
`default_nettype wire

// File: doc/sonar_median_filter.md
SONAR_MEDIAN_FILTER -- requirements
Module: sonar_median_filter

Interface
REQ-001 SHALL have parameter THRESH, default 12'd300; obstacle threshold in filtered sample units.
REQ-002 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_ctrl  input  4  [2:0] channel, [3] reserved.
REQ-005 SHALL have port in_data  input  24  [11:0] raw distance sample, [23:12] ignored.
REQ-006 SHALL have port in_wr  input  1  upstream request; sample valid.
REQ-007 SHALL have port in_rdy  output  1  sample accepted when in_wr and in_rdy are both 1 on a clk edge.
REQ-008 SHALL have port out_ctrl  output  4  {1'b0, channel}.
REQ-009 SHALL have port out_data  output  24  {12'b0, filtered sample}.
REQ-010 SHALL have port out_wr  output  1  request to send filtered result.
REQ-011 SHALL have port out_wr_rdy  input  1  downstream accepts result while out_wr=1.
REQ-012 SHALL have port obstacle  output  6  per-channel obstacle flag.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> SEND -> IDLE.
REQ-014 SHALL drive in_rdy=1 only in IDLE; out_wr=1 only in SEND.
REQ-015 IDLE: on accept, latch ch=in_ctrl[2:0], s=in_data[11:0]; go to CALC.
REQ-016 IDLE: accepted beat with in_ctrl[3]=1 or ch>5 SHALL be dropped; FSM stays IDLE; no state, output or flag change.
REQ-017 Per channel, SHALL keep two history samples h0 (newest) and h1, plus a fill count cnt (0..2, saturating).
REQ-018 CALC, s!=0, cnt=2: result=median(s,h0,h1) (middle value, unsigned 12-bit compare; ties return the equal value).
REQ-019 CALC, s!=0, cnt<2: result=s.
REQ-020 CALC, s!=0: h1<=h0, h0<=s, cnt<=min(cnt+1,2).
REQ-021 CALC, s=0 (no echo): result=0; history and cnt unchanged; obstacle[ch]<=0.
REQ-022 CALC, s!=0: obstacle[ch]<=(result<THRESH).
REQ-023 CALC: register out_ctrl/out_data from ch and result; go to SEND.
REQ-024 SEND: hold out_wr, out_ctrl, out_data stable until out_wr_rdy=1; on that edge, drop out_wr and go to IDLE.
REQ-025 Latency: accept on edge N; out_wr=1 after edge N+2; earliest next accept on edge N+4 (out_wr_rdy already high).
REQ-026 Backpressure: while out_wr_rdy=0, in_rdy SHALL stay 0; no input is lost or overwritten.
REQ-027 obstacle bits of channels other than ch SHALL be unaffected by any beat.

Reset
REQ-028 On rst=1, asynchronously: FSM=IDLE, in_rdy=1, out_wr=0, out_ctrl=0, out_data=0, obstacle=0, all h0/h1=0, all cnt=0.
REQ-029 rst asserted during CALC or SEND SHALL abort the pending result; no out_wr after rst deassertion until a new accept.

Configuration
REQ-030 Macro SONAR_MEDIAN_FILTER_EN defined: median path per REQ-017..REQ-020.
REQ-031 Macro SONAR_MEDIAN_FILTER_EN undefined: result=s always; history and cnt logic absent; FSM, handshake, latency, obstacle and reset behaviour unchanged.

Verification
REQ-032 Reset, then ch2 samples 400,100,500 with out_wr_rdy=1 -> outputs 400,100,400; obstacle[2] sequence 0,1,0.
REQ-033 ch0 sample 250 -> out_ctrl=4'h0, out_data=24'd250, obstacle=6'b000001, out_wr high exactly 1 cycle at edge N+2.
REQ-034 out_wr_rdy=0 for 10 cycles after out_wr rises -> out_wr and out_data held, in_rdy=0 throughout; result accepted on release.
REQ-035 ch3 history 200,200; then sample 0 -> out_data=0, obstacle[3]=0; then sample 600 -> out_data=200 (median of 600,200,200).
REQ-036 in_ctrl=4'h6 or 4'h8 with in_wr -> no out_wr, obstacle unchanged, in_rdy stays 1; rst pulse during SEND -> out_wr=0 immediately, obstacle=0.
